i2s_tx_serializer: RTL and testbench



---
 rtl/i2s_tx_serializer.sv | 121 ++++++++++++
 tb/tb_i2s_tx_serializer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// Stereo PCM to I2S transmitter: BCLK/LRCLK generation, one-pair holding buffer, underrun flag.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun frame repeats the last loaded pair instead of zeros.
module i2s_tx_serializer #(
  parameter int DATA_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(DATA_W);

  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_cnt_nxt;
  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] idle_word;
  logic [FRAME_W-1:0] load_word;
  logic [DATA_W-1:0]  buf_left;
  logic [DATA_W-1:0]  buf_right;
  logic               buf_full;
  logic               div_tc;
  logic               fall_evt;
  logic               load_evt;
  logic               accept;

  assign div_tc      = (div_cnt == DIV_LAST);
  assign fall_evt    = div_tc && i2s_bclk;
  assign load_evt    = fall_evt && (bit_cnt == BIT_LAST);
  assign bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
  assign accept      = in_valid && !buf_full;
  assign in_ready    = !buf_full;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [FRAME_W-1:0] last_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pair <= '0;
    end else if (load_evt && buf_full) begin
      last_pair <= {buf_left, buf_right};
    end
  end

  assign idle_word = last_pair;
`else
  assign idle_word = '0;
`endif

  assign load_word = buf_full ? {buf_left, buf_right} : idle_word;

  // NOTE: pure data holding registers carry no reset; buf_full alone decides whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_left  <= left_in;
      buf_right <= right_in;
    end
  end

  // NOTE: every register update below is non-blocking so all state samples pre-edge values in the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= BIT_LAST;
      shift_q     <= '0;
      buf_full    <= 1'b0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b1;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (div_tc) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // The registered sdata trails the shift MSB by one BCLK, giving the I2S one-bit delay.
      if (fall_evt) begin
        bit_cnt   <= bit_cnt_nxt;
        i2s_lrclk <= (bit_cnt_nxt >= BIT_HALF);
        i2s_sdata <= shift_q[FRAME_W-1];
        if (load_evt) begin
          shift_q     <= load_word;
          frame_start <= 1'b1;
          underrun    <= !buf_full;
        end else begin
          shift_q <= {shift_q[FRAME_W-2:0], 1'b0};
        end
      end

      // An accept on a load clk can only happen with the buffer empty, so it must win.
      if (accept) begin
        buf_full <= 1'b1;
      end else if (load_evt) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: a DAC-style receiver rebuilds frames and checks them against queued expectations.
module tb_i2s_tx_serializer;

  localparam int DATA_W    = 16;
  localparam int BCLK_DIV  = 4;
  localparam int FRAME_CLK = 4 * DATA_W * BCLK_DIV;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] left_in = '0;
  logic [DATA_W-1:0] right_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              i2s_bclk;
  logic              i2s_lrclk;
  logic              i2s_sdata;
  logic              frame_start;
  logic              underrun;

  i2s_tx_serializer #(.DATA_W(DATA_W), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready), .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        ur;
  } exp_t;

  exp_t        exp_q[$];
  logic        obs_ur_q[$];
  int          total = 0;
  int          bad = 0;
  int          frames_seen = 0;
  logic [31:0] last_pair = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ur_word();
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    return last_pair;
`else
    return 32'h0;
`endif
  endfunction

  task automatic push_ur();
    exp_q.push_back(exp_t'{data: ur_word(), ur: 1'b1});
  endtask

  task automatic push_pair(input logic [31:0] d);
    exp_q.push_back(exp_t'{data: d, ur: 1'b0});
    last_pair = d;
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [11:0] c;
    c = 12'(k);
    return {4'hC, c, 4'h3, ~c};
  endfunction

  // Receiver: samples on BCLK rising edges; the bit taken as LRCLK falls closes the previous frame.
  logic        prev_bclk = 1'b0;
  logic        prev_lr = 1'b1;
  logic        synced = 1'b0;
  logic [31:0] rx_shift = '0;
  int          rx_cnt = 0;
  int          rx_hi = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bclk = 1'b0;
      prev_lr   = 1'b1;
      synced    = 1'b0;
      rx_cnt    = 0;
      rx_hi     = 0;
      obs_ur_q.delete();
    end else begin
      if (frame_start) obs_ur_q.push_back(underrun);
      else if (underrun) check("stray_underrun", underrun, 0);
      if (i2s_bclk && !prev_bclk) begin
        rx_shift = {rx_shift[30:0], i2s_sdata};
        if (prev_lr && !i2s_lrclk) begin
          if (synced) begin
            check("frame_bits", rx_cnt, 32);
            check("frame_lr_high_bits", rx_hi, 16);
            if (exp_q.size() == 0 || obs_ur_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL scoreboard_empty: got frame %h want no frame", rx_shift);
            end else begin
              e = exp_q.pop_front();
              check("frame_data", rx_shift, e.data);
              check("frame_underrun", obs_ur_q.pop_front(), e.ur);
              frames_seen++;
            end
          end
          synced = 1'b1;
          rx_cnt = 1;
          rx_hi  = 0;
        end else begin
          rx_cnt++;
          if (i2s_lrclk) rx_hi++;
        end
        prev_lr = i2s_lrclk;
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic wait_frame(input string name, output int at);
    int n = 0;
    at = -1;
    while (n < FRAME_CLK + 64) begin
      @(negedge clk);
      n++;
      if (frame_start) begin
        at = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: got no frame_start in %0d clk want one", name, n);
  endtask

  task automatic send(input string name, input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    left_in  = l;
    right_in = r;
    in_valid = 1'b1;
    while (!in_ready && n < 2 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    left_in  = 16'h5A5A;
    right_in = 16'hA5A5;
    check({name, "_ready_low"}, in_ready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t_prev, t, cnt, loads, n;
    logic acc_pending;

    in_valid = 1'b1;
    left_in  = 16'hFFFF;
    right_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_bclk", i2s_bclk, 0);
    check("rst_lrclk", i2s_lrclk, 1);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    rel = cyc;

    // Startup frame plays silence, then A5C3/0F0F.
    push_ur();
    wait_frame("first_load", t);
    check("first_load_clk", t - rel, 2 * BCLK_DIV);
    t_prev = t;
    push_pair(32'hA5C30F0F);
    send("a", 16'hA5C3, 16'h0F0F);
    wait_frame("a_load", t);
    check("a_spacing", t - t_prev, FRAME_CLK);
    check("a_underrun", underrun, 0);
    t_prev = t;

    // Starvation: one underrun per frame.
    for (int i = 0; i < 4; i++) begin
      push_ur();
      wait_frame("starve", t);
      check("starve_spacing", t - t_prev, FRAME_CLK);
      check("starve_underrun", underrun, 1);
      t_prev = t;
    end

    // Continuous stream of numbered pairs over 8 frames.
    cnt = 0;
    loads = 0;
    n = 0;
    in_valid = 1'b1;
    {left_in, right_in} = pat(cnt);
    while (loads < 8 && n < 10 * FRAME_CLK) begin
      acc_pending = in_ready;
      if (acc_pending) push_pair(pat(cnt));
      @(negedge clk);
      n++;
      if (acc_pending) begin
        check("stream_ready_drop", in_ready, 0);
        cnt++;
        {left_in, right_in} = pat(cnt);
      end
      if (frame_start) begin
        check("stream_ready_rise", in_ready, 1);
        check("stream_spacing", cyc - t_prev, FRAME_CLK);
        t_prev = cyc;
        loads++;
      end
    end
    in_valid = 1'b0;
    check("stream_loads", loads, 8);

    // Pair offered exactly on the load clk with an empty buffer.
    push_ur();
    repeat (FRAME_CLK - 1) @(negedge clk);
    in_valid = 1'b1;
    left_in  = 16'h7E81;
    right_in = 16'h8421;
    @(negedge clk);
    in_valid = 1'b0;
    check("late_frame_start", frame_start, 1);
    check("late_underrun", underrun, 1);
    check("late_ready_low", in_ready, 0);
    push_pair(32'h7E818421);
    t_prev = cyc;
    wait_frame("late_play", t);
    check("late_play_spacing", t - t_prev, FRAME_CLK);
    check("late_play_underrun", underrun, 0);
    push_ur();
    wait_frame("pre_reset", t);
    t_prev = t;

    // Buffer a pair, then reset at bit_cnt 10 of the frame.
    repeat (5) @(negedge clk);
    send("doomed", 16'hDEAD, 16'hBEEF);
    n = 0;
    while (cyc - t_prev < 84 && n < FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bclk", i2s_bclk, 0);
    check("mid_rst_lrclk", i2s_lrclk, 1);
    check("mid_rst_sdata", i2s_sdata, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    last_pair = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    push_ur();
    wait_frame("post_rst_load", t);
    check("post_rst_load_clk", t - rel, 2 * BCLK_DIV);
    check("post_rst_underrun", underrun, 1);

    // One pair, then starve: underrun frames follow it.
    push_pair(32'h12348000);
    send("rep", 16'h1234, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push_ur();
      wait_frame("rep_frame", t);
    end
    repeat (8) @(negedge clk);

    check("frames_seen", frames_seen, 20);
    check("leftover_exp", exp_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
